// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// Next-fetch program counter: redirect load, sequential increment, pc+4.
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        i_load,
  input  logic [31:0] i_target,
  input  logic        i_incr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4
);

  logic [31:0] r_pc;

  // Redirect wins over increment; targets are always forced to a word boundary.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= word_align(i_target);
    end else if (i_incr) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign o_pc  = r_pc;
  assign o_pc4 = r_pc + 32'd4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs one req/ack memory transaction at a time,
// and presents {PC, PC4, instruction} to IF/ID until consumed or redirected.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] instruction,
  output logic        inst_valid
);

  fetch_state_e r_state, w_state_nxt;
  logic         r_squash, w_squash_nxt;
  logic         w_load, w_incr, w_deliver, w_consume;
  logic [31:0]  w_pc, w_pc4;
  logic [31:0]  r_pc_out, r_pc4_out, r_instr;
  logic         r_valid;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .i_load   (w_load),
    .i_target (branch_target),
    .i_incr   (w_incr),
    .o_pc     (w_pc),
    .o_pc4    (w_pc4)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state  <= S_REQ;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_squash <= w_squash_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_squash_nxt = r_squash;
    w_load       = 1'b0;
    w_incr       = 1'b0;
    w_deliver    = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      S_REQ: begin
        w_state_nxt = S_WAIT;
        if (branch_taken) begin
          w_load       = 1'b1;
          w_squash_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          // A redirect arriving with the ack makes this response stale too.
          if (r_squash || branch_taken) begin
            w_squash_nxt = 1'b0;
            w_load       = branch_taken;
            w_state_nxt  = S_REQ;
          end else begin
            w_deliver   = 1'b1;
            w_incr      = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (branch_taken) begin
          w_load       = 1'b1;
          w_squash_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          w_load      = 1'b1;
          w_consume   = 1'b1;
          w_state_nxt = S_REQ;
        end else if (!stall) begin
          w_consume   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_pc_out  <= 32'h0;
      r_pc4_out <= 32'h0;
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
    end else if (w_deliver) begin
      r_pc_out  <= w_pc;
      r_pc4_out <= w_pc4;
      r_instr   <= imem_rdata;
      r_valid   <= 1'b1;
    end else if (w_consume) begin
      r_valid   <= 1'b0;
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = word_align(w_pc);
  assign PC          = r_pc_out;
  assign PC4         = r_pc4_out;
  assign instruction = r_instr;
  assign inst_valid  = r_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench: a memory responder plus a transaction-level fetch-stream
// model push expected deliveries; a monitor pops and checks them.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK, RESETn, stall, branch_taken, imem_req, imem_ack, inst_valid;
  logic [31:0] branch_target, imem_addr, imem_rdata, PC, PC4, instruction;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .CLK           (CLK),
    .RESETn        (RESETn),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .PC            (PC),
    .PC4           (PC4),
    .instruction   (instruction),
    .inst_valid    (inst_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Fetch-stream model: address the next delivered instruction must have,
  // plus the single outstanding memory transaction.
  logic [31:0] m_next;
  bit          outstanding;
  bit          stale;
  logic [31:0] req_addr;
  int          lat;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00A0_0093;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_PC", PC, 32'h0);
    chk("rst_PC4", PC4, 32'h0);
    chk("rst_instruction", instruction, NOP);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h1);
    chk("rst_imem_addr", imem_addr, RST_PC);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0203;
      2:       return 32'h0000_0040;
      3:       return 32'hFFFF_FFFC;
      4:       return 32'hFFFF_FFF8;
      default: return $urandom & 32'h0000_FFFF;
    endcase
  endfunction

  // One cycle of stimulus, called just after a rising edge.
  task automatic step(input bit allow_br, input bit force_spur);
    bit          fresh, ack_now, br;
    logic [31:0] tgt;
    fresh   = 1'b0;
    ack_now = 1'b0;
    tgt     = 32'h0;
    if (imem_req) begin
      chk("imem_addr", imem_addr, m_next);
      if (outstanding) begin
        errors++;
        $display("FAIL req_while_busy: got req at %h expected none", imem_addr);
      end
      outstanding = 1'b1;
      fresh       = 1'b1;
      stale       = 1'b0;
      req_addr    = imem_addr;
      lat         = $urandom_range(1, 3);
    end else if (outstanding) begin
      lat--;
      if (lat == 0) ack_now = 1'b1;
    end
    br = allow_br && ($urandom_range(0, 9) == 0);
    if (br) begin
      tgt    = pick_target();
      m_next = tgt & 32'hFFFF_FFFC;
      if (outstanding) stale = 1'b1;
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (ack_now) begin
      imem_ack    = 1'b1;
      imem_rdata  = memf(req_addr);
      outstanding = 1'b0;
      if (!stale) begin
        exp_q.push_back('{pc: req_addr, pc4: req_addr + 32'd4, ins: memf(req_addr)});
        m_next = req_addr + 32'd4;
      end
    end else if ((force_spur || $urandom_range(0, 7) == 0) && !(outstanding && !fresh)) begin
      imem_ack = 1'b1;
    end
    branch_taken  = br;
    branch_target = tgt;
    stall         = ($urandom_range(0, 2) == 0);
  endtask

  task automatic advance();
    @(posedge CLK);
    #2;
  endtask

  // Monitor: pops expectations on each new delivery and checks hold/drop behaviour.
  logic        prev_valid, prev_stall, prev_br;
  logic [31:0] prev_pc, prev_pc4, prev_ins;
  int          idle;

  always @(negedge CLK) begin
    if (!RESETn) begin
      prev_valid = 1'b0;
      idle       = 0;
    end else begin
      if (inst_valid && !prev_valid) begin
        idle = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got PC %h expected no delivery", PC);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("deliver_PC", PC, e.pc);
          chk("deliver_PC4", PC4, e.pc4);
          chk("deliver_instruction", instruction, e.ins);
        end
      end else begin
        idle++;
        if (idle > 300) begin
          checks++;
          errors++;
          $display("FAIL delivery_timeout: got no delivery in %0d cycles expected one", idle);
          idle = 0;
        end
      end
      if (prev_valid) begin
        if (prev_stall && !prev_br) begin
          chk("hold_valid", {31'h0, inst_valid}, 32'h1);
          chk("hold_PC", PC, prev_pc);
          chk("hold_PC4", PC4, prev_pc4);
          chk("hold_instruction", instruction, prev_ins);
        end else begin
          chk("consume_valid", {31'h0, inst_valid}, 32'h0);
        end
      end
      prev_valid = inst_valid;
      prev_stall = stall;
      prev_br    = branch_taken;
      prev_pc    = PC;
      prev_pc4   = PC4;
      prev_ins   = instruction;
    end
  end

  initial begin
    int waited;
    RESETn = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    m_next = RST_PC; outstanding = 1'b0; stale = 1'b0; req_addr = 32'h0; lat = 0;
    #3 RESETn = 1'b0;
    #1 chk_reset_vals();
    @(posedge CLK);
    @(posedge CLK);
    #2 RESETn = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      step(1'b1, 1'b0);
      advance();
    end

    // Drive until a fetch is waiting on memory, then reset underneath it.
    waited = 0;
    while (!(outstanding && !imem_req) && waited < 20) begin
      step(1'b0, 1'b0);
      advance();
      waited++;
    end
    chk("reach_wait", {31'h0, outstanding}, 32'h1);
    imem_ack = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    RESETn = 1'b0;
    #1 chk_reset_vals();
    exp_q.delete();
    m_next = RST_PC; outstanding = 1'b0; stale = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2 RESETn = 1'b1;

    // First cycle after release also carries a late ack, which must be ignored.
    step(1'b0, 1'b1);
    advance();
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 1'b0);
      advance();
    end

    imem_ack = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
